// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: FSM encoding and default latencies.
package md_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_e;

    localparam int unsigned MD_WIDTH       = 32;
    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage : md_pkg

// File: rtl/md_unit_if.sv
// EX-stage bundle between the core and the multiply/divide unit.
interface md_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             flush;
    logic             mult;
    logic             multu;
    logic             div;
    logic             divu;
    logic             madd;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Core side: issues the decoded instruction and reads HI/LO.
    modport master (
        output start, flush, mult, multu, div, divu, madd, mthi, mtlo, rs_val, rt_val,
        input  busy, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, flush, mult, multu, div, divu, madd, mthi, mtlo, rs_val, rt_val,
        output busy, hi, lo
    );
endinterface : md_unit_if

// File: rtl/md_datapath.sv
// Combinational arithmetic for md_unit: products, multiply-accumulate sum, quotient/remainder.
module md_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   rs_i,
    input  logic [WIDTH-1:0]   rt_i,
    input  logic [WIDTH-1:0]   hi_i,
    input  logic [WIDTH-1:0]   lo_i,
    input  logic               signed_div_i,
    output logic [2*WIDTH-1:0] prod_s_o,
    output logic [2*WIDTH-1:0] prod_u_o,
    output logic [2*WIDTH-1:0] madd_o,
    output logic [WIDTH-1:0]   quot_o,
    output logic [WIDTH-1:0]   rem_o,
    output logic               div_zero_o
);
    logic [2*WIDTH-1:0] rs_sx, rt_sx, rs_zx, rt_zx;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag;

    // Extending to 2*WIDTH makes the truncated product exact for both signednesses.
    assign rs_sx    = {{WIDTH{rs_i[WIDTH-1]}}, rs_i};
    assign rt_sx    = {{WIDTH{rt_i[WIDTH-1]}}, rt_i};
    assign rs_zx    = {{WIDTH{1'b0}}, rs_i};
    assign rt_zx    = {{WIDTH{1'b0}}, rt_i};
    assign prod_s_o = rs_sx * rt_sx;
    assign prod_u_o = rs_zx * rt_zx;
    assign madd_o   = {hi_i, lo_i} + prod_s_o;

    // Sign-magnitude divide: truncates toward zero, remainder takes the dividend's sign.
    // MIN / -1 falls out naturally: magnitude 2^(W-1) negates back to itself.
    assign neg_a      = signed_div_i & rs_i[WIDTH-1];
    assign neg_b      = signed_div_i & rt_i[WIDTH-1];
    assign a_mag      = neg_a ? -rs_i : rs_i;
    assign b_mag      = neg_b ? -rt_i : rt_i;
    assign div_zero_o = (rt_i == '0);
    assign b_safe     = div_zero_o ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign quot_o     = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem_o      = neg_a ? -r_mag : r_mag;

endmodule : md_datapath

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO. Results are computed at accept, held in pending regs,
// and committed to HI/LO once the modelled latency has elapsed.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = MD_WIDTH,
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input logic clk,
    input logic rst_n,
    md_unit_if.slave md
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    md_state_e          state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               busy, acc;
    logic [2*WIDTH-1:0] prod_s, prod_u, madd_sum;
    logic [WIDTH-1:0]   quot, rem;
    logic               div_zero;

    md_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .rs_i        (md.rs_val),
        .rt_i        (md.rt_val),
        .hi_i        (hi_q),
        .lo_i        (lo_q),
        .signed_div_i(md.div),
        .prod_s_o    (prod_s),
        .prod_u_o    (prod_u),
        .madd_o      (madd_sum),
        .quot_o      (quot),
        .rem_o       (rem),
        .div_zero_o  (div_zero)
    );

    assign busy    = (state_q != MD_IDLE);
    assign acc     = md.start & ~md.flush & ~busy;
    assign md.busy = busy;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

    // Next-state: accept in IDLE, count down while busy, commit pending on the last edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        unique case (state_q)
            MD_IDLE: begin
                if (acc) begin
                    if (md.mthi) begin
                        hi_d = md.rs_val;
                    end else if (md.mtlo) begin
                        lo_d = md.rs_val;
                    end else if (md.mult || md.multu || md.madd) begin
                        if (md.mult) begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                        end else if (md.multu) begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                        end else begin
                            {pend_hi_d, pend_lo_d} = madd_sum;
                        end
                        state_d = MD_MUL;
                        cnt_d   = CntW'(MULT_CYCLES - 1);
                    end else if (md.div || md.divu) begin
                        // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
                        if (div_zero) begin
                            pend_hi_d = hi_q;
                            pend_lo_d = lo_q;
                        end else begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                        end
                        state_d = MD_DIV;
                        cnt_d   = CntW'(DIV_CYCLES - 1);
                    end
                end
            end
            MD_MUL, MD_DIV: begin
                if (cnt_q == '0) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

endmodule : md_unit

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;
    import md_pkg::*;

    // Op vector order: {mult, multu, div, divu, madd, mthi, mtlo}
    localparam logic [6:0] OpMult  = 7'b1000000;
    localparam logic [6:0] OpMultu = 7'b0100000;
    localparam logic [6:0] OpDiv   = 7'b0010000;
    localparam logic [6:0] OpDivu  = 7'b0001000;
    localparam logic [6:0] OpMadd  = 7'b0000100;
    localparam logic [6:0] OpMthi  = 7'b0000010;
    localparam logic [6:0] OpMtlo  = 7'b0000001;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    md_unit_if #(.WIDTH(32)) bus_if ();

    md_unit #(
        .WIDTH      (32),
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .md   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol checks on what the bench drives.
    always @(posedge clk) begin
        if (rst_n && bus_if.start) begin
            assert ($onehot0({bus_if.mult, bus_if.multu, bus_if.div, bus_if.divu,
                              bus_if.madd, bus_if.mthi, bus_if.mtlo}))
                else $error("protocol: more than one op bit set");
            assert (!bus_if.busy) else $error("protocol: start while busy");
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [6:0] ops);
        {bus_if.mult, bus_if.multu, bus_if.div, bus_if.divu,
         bus_if.madd, bus_if.mthi, bus_if.mtlo} = ops;
    endtask

    // Issue one instruction, count busy cycles (bounded), check HI/LO hold and final values.
    task automatic run_op(input string tag, input logic [6:0] ops, input logic [31:0] rs,
                          input logic [31:0] rt, input logic flush, input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0, lo0;
        int          n;
        @(negedge clk);
        hi0 = bus_if.hi;
        lo0 = bus_if.lo;
        set_ops(ops);
        bus_if.rs_val = rs;
        bus_if.rt_val = rt;
        bus_if.flush  = flush;
        bus_if.start  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.flush = 1'b0;
        set_ops(7'b0);
        n = 0;
        while (bus_if.busy && n < 100) begin
            check_eq({tag, " hold hi"}, 64'(bus_if.hi), 64'(hi0));
            check_eq({tag, " hold lo"}, 64'(bus_if.lo), 64'(lo0));
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, " busy cycles"}, 64'(n), 64'(exp_cycles));
        check_eq({tag, " hi"}, 64'(bus_if.hi), 64'(exp_hi));
        check_eq({tag, " lo"}, 64'(bus_if.lo), 64'(exp_lo));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.flush  = 1'b0;
        bus_if.rs_val = '0;
        bus_if.rt_val = '0;
        set_ops(7'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset busy", 64'(bus_if.busy), 64'd0);
        check_eq("reset hi", 64'(bus_if.hi), 64'd0);
        check_eq("reset lo", 64'(bus_if.lo), 64'd0);
        rst_n = 1'b1;

        // -3 * 7 = -21
        run_op("mult", OpMult, 32'hFFFF_FFFD, 32'd7, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        // (2^32-1) * 2
        run_op("multu", OpMultu, 32'hFFFF_FFFF, 32'd2, 1'b0, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        // -7 / 2 = -3 rem -1
        run_op("div", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", OpDivu, 32'd7, 32'd2, 1'b0, 10, 32'd1, 32'd3);
        // divu of a "negative" pattern treated as unsigned: 0xFFFFFFF9 / 2
        run_op("divu big", OpDivu, 32'hFFFF_FFF9, 32'd2, 1'b0, 10, 32'd1, 32'h7FFF_FFFC);
        // Signed overflow case
        run_op("div min/-1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0,
               32'h8000_0000);
        // Divide by zero keeps HI/LO
        run_op("mthi A", OpMthi, 32'hA, 32'd0, 1'b0, 0, 32'hA, 32'h8000_0000);
        run_op("mtlo B", OpMtlo, 32'hB, 32'd0, 1'b0, 0, 32'hA, 32'hB);
        run_op("div by 0", OpDiv, 32'd5, 32'd0, 1'b0, 10, 32'hA, 32'hB);
        // Move-to and multiply-accumulate: {0x12345678, 5} + 2*3
        run_op("mthi", OpMthi, 32'h1234_5678, 32'd0, 1'b0, 0, 32'h1234_5678, 32'hB);
        run_op("mtlo", OpMtlo, 32'd5, 32'd0, 1'b0, 0, 32'h1234_5678, 32'd5);
        run_op("madd", OpMadd, 32'd2, 32'd3, 1'b0, 5, 32'h1234_5678, 32'h0000_000B);
        // madd with negative product borrowing across LO into HI: 0x12345678_0000000B - 12
        run_op("madd neg", OpMadd, 32'hFFFF_FFFE, 32'd6, 1'b0, 5, 32'h1234_5677,
               32'hFFFF_FFFF);
        // Flushed start is not accepted
        run_op("flush mult", OpMult, 32'd9, 32'd9, 1'b1, 0, 32'h1234_5677, 32'hFFFF_FFFF);

        // Async reset in busy cycle 4 of a divide
        @(negedge clk);
        set_ops(OpDiv);
        bus_if.rs_val = 32'd100;
        bus_if.rt_val = 32'd3;
        bus_if.start  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        set_ops(7'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("busy before reset", 64'(bus_if.busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async reset busy", 64'(bus_if.busy), 64'd0);
        check_eq("async reset hi", 64'(bus_if.hi), 64'd0);
        check_eq("async reset lo", 64'(bus_if.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Unit recovers cleanly after the aborted divide
        run_op("mult after reset", OpMult, 32'd3, 32'd4, 1'b0, 5, 32'd0, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_md_unit
